// File: rtl/frame_burst_reader.sv
// rtl/frame_burst_reader.sv - splits a frame read into SDRAM bursts and forwards beats to the display FIFO
module frame_burst_reader #(
  parameter int SDRAM_ADDRS_DW = 21,
  parameter int BURST_LEN      = 64,
  parameter int DATA_DW        = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_start,
  input  logic [SDRAM_ADDRS_DW-1:0] i_mem_addrs,
  input  logic [31:0]               i_data_length,
  output logic                      o_rd_req,
  output logic [SDRAM_ADDRS_DW-1:0] o_rd_addrs,
  output logic [7:0]                o_rd_len,
  input  logic                      i_rd_ack,
  input  logic                      i_rd_valid,
  input  logic [DATA_DW-1:0]        i_rd_data,
  input  logic                      i_fifo_space_ok,
  output logic                      o_fifo_wr,
  output logic [DATA_DW-1:0]        o_fifo_wdata,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_start_drop
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_REQ,
    S_DATA,
    S_DONE
  } state_t;

  localparam logic [31:0] BURST_LEN_32 = 32'(BURST_LEN);

  state_t                    state_q, state_d;
  logic [SDRAM_ADDRS_DW-1:0] cur_addr_q, cur_addr_d;
  logic [31:0]               remaining_q, remaining_d;
  logic [7:0]                burst_q, burst_d;
  logic [7:0]                beat_q, beat_d;
  logic                      rd_req_q, rd_req_d;
  logic [SDRAM_ADDRS_DW-1:0] rd_addrs_q, rd_addrs_d;
  logic [7:0]                rd_len_q, rd_len_d;
  logic                      fifo_wr_q, fifo_wr_d;
  logic [DATA_DW-1:0]        fifo_wdata_q, fifo_wdata_d;
  logic                      frame_done_q, frame_done_d;
  logic                      start_drop_q, start_drop_d;
  logic [7:0]                burst_sel;

  // Next burst size: whatever is left of the frame, capped at BURST_LEN
  always_comb begin
    burst_sel = BURST_LEN_32[7:0];
    if (remaining_q < BURST_LEN_32) begin
      burst_sel = remaining_q[7:0];
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    rd_req_d     = rd_req_q;
    rd_addrs_d   = rd_addrs_q;
    rd_len_d     = rd_len_q;
    fifo_wr_d    = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    frame_done_d = 1'b0;
    start_drop_d = i_mem_start && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (i_mem_start) begin
          cur_addr_d  = i_mem_addrs;
          remaining_d = i_data_length;
          state_d     = (i_data_length == 32'd0) ? S_DONE : S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        if (i_fifo_space_ok) begin
          burst_d    = burst_sel;
          rd_req_d   = 1'b1;
          rd_addrs_d = cur_addr_q;
          rd_len_d   = burst_sel;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (i_rd_ack) begin
          rd_req_d = 1'b0;
          beat_d   = burst_q;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (i_rd_valid) begin
          fifo_wr_d    = 1'b1;
          fifo_wdata_d = i_rd_data;
          beat_d       = beat_q - 8'd1;
          if (beat_q == 8'd1) begin
            // Address wraps silently at the top of SDRAM
            cur_addr_d  = cur_addr_q + SDRAM_ADDRS_DW'(burst_q);
            remaining_d = remaining_q - 32'(burst_q);
            state_d     = (remaining_q == 32'(burst_q)) ? S_DONE : S_WAIT_SPACE;
          end
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      rd_req_q     <= 1'b0;
      rd_addrs_q   <= '0;
      rd_len_q     <= '0;
      fifo_wr_q    <= 1'b0;
      fifo_wdata_q <= '0;
      frame_done_q <= 1'b0;
      start_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      rd_req_q     <= rd_req_d;
      rd_addrs_q   <= rd_addrs_d;
      rd_len_q     <= rd_len_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_wdata_q <= fifo_wdata_d;
      frame_done_q <= frame_done_d;
      start_drop_q <= start_drop_d;
    end
  end

  assign o_rd_req     = rd_req_q;
  assign o_rd_addrs   = rd_addrs_q;
  assign o_rd_len     = rd_len_q;
  assign o_fifo_wr    = fifo_wr_q;
  assign o_fifo_wdata = fifo_wdata_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_frame_done = frame_done_q;
  assign o_start_drop = start_drop_q;

endmodule

// File: doc/frame_burst_reader.md
FRAME_BURST_READER -- requirements
Module: frame_burst_reader

Interface
REQ-001 Parameter SDRAM_ADDRS_DW, default 21, SDRAM word-address width.
REQ-002 Parameter BURST_LEN, default 64, maximum words per read burst (1..255).
REQ-003 Parameter DATA_DW, default 16, SDRAM/FIFO data width.
REQ-004 i_clk  in  1  clock; all logic on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_mem_start  in  1  one-cycle pulse; start reading one frame.
REQ-007 i_mem_addrs  in  SDRAM_ADDRS_DW  frame base word address; sampled with i_mem_start.
REQ-008 i_data_length  in  32  frame length in words; sampled with i_mem_start.
REQ-009 o_rd_req  out  1  burst read request to SDRAM controller.
REQ-010 o_rd_addrs  out  SDRAM_ADDRS_DW  burst start word address.
REQ-011 o_rd_len  out  8  burst length in words.
REQ-012 i_rd_ack  in  1  controller accepted the current request.
REQ-013 i_rd_valid  in  1  read data beat valid.
REQ-014 i_rd_data  in  DATA_DW  read data beat.
REQ-015 i_fifo_space_ok  in  1  display FIFO can absorb BURST_LEN words.
REQ-016 o_fifo_wr  out  1  FIFO write strobe.
REQ-017 o_fifo_wdata  out  DATA_DW  FIFO write data.
REQ-018 o_busy  out  1  high whenever state is not IDLE.
REQ-019 o_frame_done  out  1  one-cycle pulse when the frame completes.
REQ-020 o_start_drop  out  1  one-cycle pulse when a start is ignored.

Function
REQ-021 FSM states: IDLE, WAIT_SPACE, REQ, DATA, DONE.
REQ-022 IDLE: on i_mem_start, latch cur_addr = i_mem_addrs and remaining = i_data_length; go to WAIT_SPACE, or to DONE if i_data_length == 0.
REQ-023 WAIT_SPACE: when i_fifo_space_ok is high, load burst = min(remaining, BURST_LEN) and go to REQ; otherwise stay.
REQ-024 REQ: o_rd_req = 1, o_rd_addrs = cur_addr, o_rd_len = burst, all registered and held stable until i_rd_ack is sampled high; then go to DATA with beat counter = burst.
REQ-025 o_rd_req shall be 0 in every state except REQ, and shall drop the cycle after i_rd_ack.
REQ-026 DATA: on each i_rd_valid, register o_fifo_wr = 1 and o_fifo_wdata = i_rd_data for exactly one cycle (1-cycle latency), and decrement the beat counter.
REQ-027 On the last beat of a burst:
- cur_addr += burst, modulo 2^SDRAM_ADDRS_DW (wraps, no error);
- remaining -= burst;
- go to DONE if remaining == 0, else WAIT_SPACE.
REQ-028 i_rd_valid outside DATA is ignored; no FIFO write is produced.
REQ-029 i_rd_ack outside REQ is ignored.
REQ-030 DONE: o_frame_done = 1 for one cycle, then IDLE; timing is registered, asserted on the cycle after DONE is entered.
REQ-031 i_mem_start while not IDLE: no state change; o_start_drop pulses for one cycle, next cycle.
REQ-032 i_mem_start to first o_rd_req = 2 cycles when i_fifo_space_ok is already high.
REQ-033 The sum of o_rd_len over a frame shall equal i_data_length; exactly i_data_length FIFO writes per frame.
REQ-034 i_mem_addrs and i_data_length changes outside the start cycle have no effect.

Reset
REQ-035 While i_rst_n is low at a clock edge:
- state = IDLE;
- counters and address = 0;
- o_rd_req, o_fifo_wr, o_busy, o_frame_done, o_start_drop = 0;
- o_rd_addrs, o_rd_len, o_fifo_wdata = 0.
REQ-036 Reset mid-frame aborts the frame with no o_frame_done; beats arriving after reset are ignored.

Verification
REQ-037 Addr 0x10000, length 49152 (256x192), space_ok = 1, ack 1 cycle after req -> 768 requests, len 64 each, last o_rd_addrs 0x1BFC0, 49152 FIFO writes, one o_frame_done.
REQ-038 Addr 0x00100, length 100 -> two requests: (0x00100, 64) then (0x00140, 36); data passes through in order with 1-cycle latency.
REQ-039 Length 0 -> no o_rd_req, no o_fifo_wr, o_frame_done pulse 2 cycles after start.
REQ-040 Addr 0x1FFFE0, length 64, BURST_LEN 32 -> second request addr 0x000000 (wrap).
REQ-041 space_ok low for 50 cycles between bursts, plus a second start mid-frame -> o_rd_req held 0 while low; o_start_drop pulses once; frame still completes.
REQ-042 Reset asserted mid-DATA, followed by stray i_rd_valid -> all outputs 0, no FIFO writes, next start behaves normally.
